// File: rtl/router_wr_ctrl.sv
// Router write controller: parses header/payload/parity bytes from the source,
// steers them into one of three FIFOs and flushes FIFOs that sit unread too long.
module router_wr_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       err,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, CHECK_PARITY, DROP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] header_q, header_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] rx_parity_q, rx_parity_d;
  logic [5:0] byte_cnt_q, byte_cnt_d;
  logic       err_q, err_d;
  logic       wr_req;
  logic       flush;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fifo
      logic [4:0] tmo_cnt_q, tmo_cnt_d;
      logic       pulse_q, pulse_d;
      logic       idle;

      assign vld_out[gi]    = ~fifo_empty[gi];
      assign idle           = vld_out[gi] & ~read_enb[gi];
      assign write_enb[gi]  = wr_req & (addr_q == 2'(gi));
      assign soft_reset[gi] = pulse_q;

      always_comb begin
        tmo_cnt_d = '0;
        pulse_d   = 1'b0;
        if (idle) begin
          if (tmo_cnt_q == 5'(TIMEOUT - 1)) pulse_d = 1'b1;
          else tmo_cnt_d = tmo_cnt_q + 5'd1;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          tmo_cnt_q <= '0;
          pulse_q   <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_d;
          pulse_q   <= pulse_d;
        end
      end
    end
  endgenerate

  assign flush    = soft_reset[addr_q];
  assign data_out = (state_q == LOAD_FIRST_DATA) ? header_q : data_in;
  assign err      = err_q;

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    addr_d      = addr_q;
    parity_d    = parity_q;
    rx_parity_d = rx_parity_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    wr_req      = 1'b0;
    lfd_state   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      DECODE: begin
        if (pkt_valid) begin
          if (data_in[1:0] == 2'd3) begin
            state_d = DROP;
          end else begin
            header_d = data_in;
            addr_d   = data_in[1:0];
            err_d    = 1'b0;
            state_d  = fifo_empty[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (flush) state_d = pkt_valid ? DROP : DECODE;
        else if (fifo_empty[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy = 1'b1;
        if (flush) begin
          state_d = pkt_valid ? DROP : DECODE;
        end else if (!fifo_full[addr_q]) begin
          wr_req     = 1'b1;
          lfd_state  = 1'b1;
          parity_d   = header_q;
          byte_cnt_d = '0;
          state_d    = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (flush) begin
          busy    = 1'b1;
          state_d = pkt_valid ? DROP : DECODE;
        end else if (fifo_full[addr_q]) begin
          busy = 1'b1;
        end else begin
          wr_req = 1'b1;
          if (pkt_valid) begin
            parity_d = parity_q ^ data_in;
            if (byte_cnt_q != 6'h3f) byte_cnt_d = byte_cnt_q + 6'd1;
          end else begin
            rx_parity_d = data_in;
            state_d     = CHECK_PARITY;
          end
        end
      end
      CHECK_PARITY: begin
        busy    = 1'b1;
        err_d   = (rx_parity_q != parity_q) | (byte_cnt_q != header_q[7:2]);
        state_d = DECODE;
      end
      DROP: begin
        // the parity byte (pkt_valid low) closes the discarded packet
        if (!pkt_valid) state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DECODE;
      header_q    <= '0;
      addr_q      <= '0;
      parity_q    <= '0;
      rx_parity_q <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      addr_q      <= addr_d;
      parity_q    <= parity_d;
      rx_parity_q <= rx_parity_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/router_wr_ctrl.md
ROUTER_WR_CTRL -- requirements
Module: router_wr_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning idle cycles a non-empty FIFO waits for a read before its soft reset fires.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port pkt_valid  in  1  high for header and payload bytes, low on the parity byte.
REQ-005 SHALL have port data_in  in  8  source byte; header = {payload_len[5:0], addr[1:0]}.
REQ-006 SHALL have port fifo_full  in  3  full flag of FIFO 0..2.
REQ-007 SHALL have port fifo_empty  in  3  empty flag of FIFO 0..2.
REQ-008 SHALL have port read_enb  in  3  destination read strobe per FIFO.
REQ-009 SHALL have port write_enb  out  3  one-hot FIFO write strobe, combinational.
REQ-010 SHALL have port lfd_state  out  1  high only in the cycle the header is written.
REQ-011 SHALL have port data_out  out  8  byte to FIFOs; header_reg in LOAD_FIRST_DATA, else data_in.
REQ-012 SHALL have port busy  out  1  source must hold data_in and pkt_valid while high.
REQ-013 SHALL have port err  out  1  parity or length mismatch of last packet.
REQ-014 SHALL have port vld_out  out  3  equals ~fifo_empty, combinational.
REQ-015 SHALL have port soft_reset  out  3  one-cycle flush pulse per FIFO.

Function
REQ-016 SHALL implement states DECODE, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, CHECK_PARITY, DROP.
REQ-017 DECODE: busy=0; pkt_valid=1 with data_in[1:0]!=3 latches header_reg and addr, goes LOAD_FIRST_DATA if fifo_empty[addr] else WAIT_TILL_EMPTY; addr=3 goes DROP; pkt_valid=0 stays.
REQ-018 WAIT_TILL_EMPTY: busy=1, no writes; exits to LOAD_FIRST_DATA the cycle fifo_empty[addr]=1.
REQ-019 LOAD_FIRST_DATA: busy=1, write_enb[addr]=1, lfd_state=1, parity_reg<=header_reg, byte_cnt<=0; next LOAD_DATA.
REQ-020 LOAD_DATA with fifo_full[addr]=1: busy=1, write_enb=0, state/counters hold (byte retried).
REQ-021 LOAD_DATA with fifo_full[addr]=0, pkt_valid=1: busy=0, write_enb[addr]=1, parity_reg^=data_in, byte_cnt+1 (6-bit saturating at 63).
REQ-022 LOAD_DATA with fifo_full[addr]=0, pkt_valid=0: writes data_in as parity byte, latches it to rx_parity, goes CHECK_PARITY.
REQ-023 CHECK_PARITY: busy=1, no writes; err<=(rx_parity!=parity_reg)|(byte_cnt!=header_reg[7:2]); next DECODE.
REQ-024 err SHALL hold until the next header is accepted in DECODE, then clear.
REQ-025 DROP: busy=0, no writes; exits to DECODE on the cycle pkt_valid=0 (parity byte discarded).
REQ-026 Per FIFO i, a 5-bit timeout counter SHALL increment while vld_out[i]=1 and read_enb[i]=0, clear on read_enb[i]=1 or vld_out[i]=0.
REQ-027 When counter i reaches TIMEOUT-1, soft_reset[i] SHALL pulse high the next cycle and the counter SHALL clear.
REQ-028 soft_reset[addr] in WAIT_TILL_EMPTY, LOAD_FIRST_DATA or LOAD_DATA SHALL force DROP next cycle, with no write in that cycle; if pkt_valid=0 that cycle, go DECODE.
REQ-029 Exactly one write_enb bit or none SHALL be high in any cycle; write_enb SHALL never assert while fifo_full of that FIFO is high.

Reset
REQ-030 reset=1 SHALL immediately force DECODE, write_enb=0, lfd_state=0, busy=0, err=0, soft_reset=0, all counters/header_reg/parity_reg=0; data_out=data_in.
REQ-031 reset mid-packet SHALL abandon the packet; after release the next pkt_valid byte is treated as a header.

Verification
REQ-032 Header 8'h39 (len 14, addr 1), FIFO 1 empty, 14 payloads, correct parity -> 16 writes on write_enb=3'b010, lfd_state high once, err=0.
REQ-033 Same packet with corrupted parity byte -> err=1 after CHECK_PARITY, cleared when next header accepted.
REQ-034 fifo_full[1] raised for 3 cycles mid-payload -> busy=1 those cycles, no writes, no byte lost, err=0.
REQ-035 Header to addr 2 with fifo_empty[2]=0 -> busy=1 in WAIT_TILL_EMPTY until fifo_empty[2]=1, then header written.
REQ-036 vld_out[0]=1, read_enb[0]=0 for 30 cycles -> soft_reset[0] one-cycle pulse; read before 30 -> no pulse.
REQ-037 Header with addr 3 -> no writes for whole packet, FSM back in DECODE after parity byte.
